tt_design_scheduler: RTL and testbench

- Shares one 8-bit user IO bank between NUM_DESIGNS user modules. Each user module takes the clock on io_in[0] and an active-high reset on io_in[1].
- Accepts select requests through a valid/ready handshake. On each switch it drains the outgoing design, pulses reset into the incoming design, then connects that design's io_out to the pads.
- Sits between the pad ring and the user-module array.

---
 rtl/tt_design_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_tt_design_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_design_scheduler.sv
// tt_design_scheduler
//
// Shares one 8-bit user IO bank between NUM_DESIGNS user modules. A select
// request (sel_valid/sel_ready) drains the outgoing design for GUARD_CYCLES
// with all clocks gated and the pads at 0. It then holds the incoming design
// in reset for RST_CYCLES and finally connects that design's io_out to the
// pads. Selecting the design that is already active restarts it (reset
// only, clocks untouched). Every output is registered.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   sel_valid   select request valid
//   sel_id      requested design index
//   sel_ready   scheduler can accept a request (high only in RUN)
//   des_io_out  flattened io_out of all designs, design k at [8k+7:8k]
//   des_clk_en  one-hot clock enable per design (gates io_in[0])
//   des_reset   per-design active-high reset (drives io_in[1])
//   io_out      registered pad output
//   active_id   currently connected design
//   busy        a switch or restart is in progress
//
// Optional feature, enabled by defining TT_SCHED_AUTO_ROTATE_EN:
//   auto_en     in  enables round-robin rotation after SLOT_CYCLES in RUN
//   sel_err     out sticky flag for an out-of-range sel_id, cleared by reset_n
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | reserved, falls through to RUN on the next cycle
// DRAIN | pads at 0, all clocks off, counting GUARD_CYCLES
// RST   | target clocked and held in reset, counting RST_CYCLES
// RUN   | active design connected to the pads, requests accepted

module tt_design_scheduler #(
    parameter int NUM_DESIGNS  = 4,
    parameter int ID_W         = 2,
    parameter int GUARD_CYCLES = 2,
    parameter int RST_CYCLES   = 4
`ifdef TT_SCHED_AUTO_ROTATE_EN
    ,
    parameter int SLOT_CYCLES  = 1000
`endif
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sel_valid,
    input  logic [ID_W-1:0]          sel_id,
    output logic                     sel_ready,
    input  logic [8*NUM_DESIGNS-1:0] des_io_out,
    output logic [NUM_DESIGNS-1:0]   des_clk_en,
    output logic [NUM_DESIGNS-1:0]   des_reset,
    output logic [7:0]               io_out,
    output logic [ID_W-1:0]          active_id,
`ifdef TT_SCHED_AUTO_ROTATE_EN
    input  logic                     auto_en,
    output logic                     sel_err,
`endif
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RST   = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [7:0] GUARD_INIT = 8'(GUARD_CYCLES);
    localparam logic [7:0] RST_INIT   = 8'(RST_CYCLES);

`ifdef TT_SCHED_AUTO_ROTATE_EN
    localparam int              SLOT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
`endif

    state_t                 state, state_nxt;
    logic [7:0]             cnt, cnt_nxt, cnt_dec;
    logic [ID_W-1:0]        target, target_nxt, active_nxt;
    logic [7:0]             io_nxt, cur_io;
    logic [NUM_DESIGNS-1:0] clk_en_nxt, reset_nxt;
    logic                   ready_nxt, busy_nxt;
    logic                   accept, in_range;
    logic                   go;
    logic [ID_W-1:0]        go_id;

`ifdef TT_SCHED_AUTO_ROTATE_EN
    logic [SLOT_W-1:0]      slot_cnt, slot_nxt;
    logic                   err_nxt;
    logic [ID_W-1:0]        next_id;
`endif

    function automatic logic [NUM_DESIGNS-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_DESIGNS-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            v[k] = (id == ID_W'(k));
        end
        return v;
    endfunction

    assign accept   = sel_valid && sel_ready;
    assign in_range = (int'(sel_id) < NUM_DESIGNS);
    // Saturating decrement: the counter never wraps past 0.
    assign cnt_dec  = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;

`ifdef TT_SCHED_AUTO_ROTATE_EN
    assign next_id = (active_id == ID_W'(NUM_DESIGNS - 1)) ? '0 : active_id + 1'b1;
`endif

    always_comb begin
        cur_io = 8'h00;
        for (int k = 0; k < NUM_DESIGNS; k++) begin
            if (active_id == ID_W'(k)) begin
                cur_io = des_io_out[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        active_nxt = active_id;
        io_nxt     = 8'h00;
        clk_en_nxt = des_clk_en;
        reset_nxt  = '1;
        ready_nxt  = 1'b0;
        busy_nxt   = 1'b1;
        go         = 1'b0;
        go_id      = sel_id;
`ifdef TT_SCHED_AUTO_ROTATE_EN
        slot_nxt   = '0;
        err_nxt    = sel_err;
`endif

        case (state)
            IDLE: begin
                state_nxt = RUN;
                reset_nxt = ~onehot(active_id);
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end

            DRAIN: begin
                clk_en_nxt = '0;
                if (cnt_dec == 8'd0) begin
                    // Hand over to the new design: its clock starts with
                    // its reset still asserted.
                    state_nxt  = RST;
                    cnt_nxt    = RST_INIT;
                    active_nxt = target;
                    clk_en_nxt = onehot(target);
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end

            RST: begin
                if (cnt_dec == 8'd0) begin
                    state_nxt = RUN;
                    cnt_nxt   = 8'd0;
                    reset_nxt = ~onehot(target);
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end

            RUN: begin
                io_nxt    = cur_io;
                reset_nxt = ~onehot(active_id);
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
`ifdef TT_SCHED_AUTO_ROTATE_EN
                slot_nxt  = slot_cnt;
`endif
                if (accept) begin
                    // Out-of-range ids are consumed but change nothing.
                    go = in_range;
`ifdef TT_SCHED_AUTO_ROTATE_EN
                    if (!in_range) begin
                        err_nxt = 1'b1;
                    end
`endif
                end
`ifdef TT_SCHED_AUTO_ROTATE_EN
                // An accepted external request takes priority over expiry.
                else if (auto_en) begin
                    if (slot_cnt == SLOT_LAST) begin
                        go    = 1'b1;
                        go_id = next_id;
                    end else begin
                        slot_nxt = slot_cnt + 1'b1;
                    end
                end
`endif
                if (go) begin
                    target_nxt = go_id;
                    io_nxt     = 8'h00;
                    reset_nxt  = '1;
                    ready_nxt  = 1'b0;
                    busy_nxt   = 1'b1;
`ifdef TT_SCHED_AUTO_ROTATE_EN
                    slot_nxt   = '0;
`endif
                    if (go_id == active_id) begin
                        // Restart in place: no guard interval, clock kept on.
                        state_nxt = RST;
                        cnt_nxt   = RST_INIT;
                    end else begin
                        state_nxt  = DRAIN;
                        cnt_nxt    = GUARD_INIT;
                        clk_en_nxt = '0;
                    end
                end
            end

            default: begin
                state_nxt = RST;
                cnt_nxt   = RST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RST;
            cnt        <= RST_INIT;
            target     <= '0;
            active_id  <= '0;
            io_out     <= 8'h00;
            des_clk_en <= onehot('0);
            des_reset  <= '1;
            sel_ready  <= 1'b0;
            busy       <= 1'b1;
`ifdef TT_SCHED_AUTO_ROTATE_EN
            slot_cnt   <= '0;
            sel_err    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            target     <= target_nxt;
            active_id  <= active_nxt;
            io_out     <= io_nxt;
            des_clk_en <= clk_en_nxt;
            des_reset  <= reset_nxt;
            sel_ready  <= ready_nxt;
            busy       <= busy_nxt;
`ifdef TT_SCHED_AUTO_ROTATE_EN
            slot_cnt   <= slot_nxt;
            sel_err    <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_tt_design_scheduler.sv
// Testbench for tt_design_scheduler (default build, GUARD=2, RST=4).
// A second instance with three designs exercises an out-of-range sel_id,
// which cannot be expressed with four designs and a 2-bit index.

module tb_tt_design_scheduler;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_valid = 1'b0;
    logic [1:0]  sel_id    = 2'd0;
    logic        sel_ready;
    logic [31:0] des_io_out;
    logic [3:0]  des_clk_en;
    logic [3:0]  des_reset;
    logic [7:0]  io_out;
    logic [1:0]  active_id;
    logic        busy;

    logic        sel_valid3 = 1'b0;
    logic [1:0]  sel_id3    = 2'd0;
    logic        sel_ready3;
    logic [23:0] des_io_out3 = {8'h33, 8'h22, 8'h11};
    logic [2:0]  des_clk_en3;
    logic [2:0]  des_reset3;
    logic [7:0]  io_out3;
    logic [1:0]  active_id3;
    logic        busy3;

    tt_design_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel_valid  (sel_valid),
        .sel_id     (sel_id),
        .sel_ready  (sel_ready),
        .des_io_out (des_io_out),
        .des_clk_en (des_clk_en),
        .des_reset  (des_reset),
        .io_out     (io_out),
        .active_id  (active_id),
        .busy       (busy)
    );

    tt_design_scheduler #(.NUM_DESIGNS(3), .ID_W(2)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel_valid  (sel_valid3),
        .sel_id     (sel_id3),
        .sel_ready  (sel_ready3),
        .des_io_out (des_io_out3),
        .des_clk_en (des_clk_en3),
        .des_reset  (des_reset3),
        .io_out     (io_out3),
        .active_id  (active_id3),
        .busy       (busy3)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges seen; read at the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] io;
        logic [3:0] en;
        logic [3:0] rs;
        logic [1:0] act;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic void expect_at(int c, string nm, logic [7:0] io, logic [3:0] en,
                                      logic [3:0] rs, logic [1:0] act, logic rdy, logic bsy);
        exp_t e;
        int   i;
        e.cyc = c; e.name = nm; e.io = io; e.en = en; e.rs = rs;
        e.act = act; e.rdy = rdy; e.bsy = bsy;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endfunction

    // Expected trace of a switch to a different design accepted at edge a.
    function automatic void exp_switch(int a, string nm, logic [1:0] old_id, logic [1:0] new_id,
                                       logic [7:0] new_io, bit with_io);
        logic [3:0] oh;
        oh = 4'b0001 << new_id;
        for (int k = 0; k < 2; k++) expect_at(a + k, nm, 8'h00, 4'b0000, 4'b1111, old_id, 1'b0, 1'b1);
        for (int k = 2; k < 6; k++) expect_at(a + k, nm, 8'h00, oh, 4'b1111, new_id, 1'b0, 1'b1);
        expect_at(a + 6, nm, 8'h00, oh, ~oh, new_id, 1'b1, 1'b0);
        if (with_io) expect_at(a + 7, nm, new_io, oh, ~oh, new_id, 1'b1, 1'b0);
    endfunction

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endfunction

    // Monitor: every cycle the registered outputs are presented; compare
    // them against whatever the scoreboard holds for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (mon_e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", mon_e.name, mon_e.cyc, cyc);
            end else if (io_out !== mon_e.io || des_clk_en !== mon_e.en || des_reset !== mon_e.rs ||
                         active_id !== mon_e.act || sel_ready !== mon_e.rdy || busy !== mon_e.bsy) begin
                n_err++;
                $display("FAIL %s @%0d: got io=%h en=%b rst=%b act=%0d rdy=%b busy=%b, want io=%h en=%b rst=%b act=%0d rdy=%b busy=%b",
                         mon_e.name, cyc, io_out, des_clk_en, des_reset, active_id, sel_ready, busy,
                         mon_e.io, mon_e.en, mon_e.rs, mon_e.act, mon_e.rdy, mon_e.bsy);
            end
        end
    end

    // Raise a request at a falling edge and return as soon as it will be
    // accepted on the next rising edge; acc is that edge's number.
    task automatic do_req(input logic [1:0] id, output int acc);
        acc = -1;
        sel_valid = 1'b1;
        sel_id    = id;
        for (int i = 0; i < 40; i++) begin
            if (sel_ready === 1'b1) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: sel_ready never high for id %0d", id);
        end
    endtask

    initial begin
        int c0, cr, a1, a2, a3, a4, a5;
        des_io_out = {8'hC3, 8'hA5, 8'h5A, 8'h3C};

        // Reset values and release timing.
        repeat (2) @(negedge clk);
        expect_at(cyc + 1, "reset_hold", 8'h00, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = cyc;
        for (int k = 1; k < 4; k++) expect_at(c0 + k, "rst_release", 8'h00, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b1);
        expect_at(c0 + 4, "first_run", 8'h00, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);
        expect_at(c0 + 5, "io_d0", 8'h3C, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);
        expect_at(c0 + 6, "io_d0", 8'h3C, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);
        while (cyc < c0 + 6) @(negedge clk);
        des_io_out[7:0] = 8'h77;
        expect_at(c0 + 7, "io_latency", 8'h77, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);

        // Out-of-range request on the three-design instance.
        @(negedge clk);
        sel_valid3 = 1'b1;
        sel_id3    = 2'd3;
        chk("oor_ready", 32'(sel_ready3), 32'd1);
        @(negedge clk);
        sel_valid3 = 1'b0;
        chk("oor_active", 32'(active_id3), 32'd0);
        chk("oor_busy", 32'(busy3), 32'd0);
        chk("oor_state", 32'({des_clk_en3, des_reset3, sel_ready3}), 32'({3'b001, 3'b110, 1'b1}));
        @(negedge clk);
        chk("oor_io", 32'({io_out3, busy3}), 32'({8'h11, 1'b0}));

        // Switch to design 2.
        do_req(2'd2, a1);
        exp_switch(a1, "sw_to2", 2'd0, 2'd2, 8'hA5, 1'b1);
        expect_at(a1 + 8, "sw_to2_hold", 8'hA5, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b0);
        @(negedge clk);
        sel_valid = 1'b0;
        while (cyc < a1 + 9) @(negedge clk);

        // Switch to 0, with a request for 1 held throughout.
        do_req(2'd0, a2);
        exp_switch(a2, "stall_to0", 2'd2, 2'd0, 8'h00, 1'b0);
        @(negedge clk);
        sel_id = 2'd1;
        do_req(2'd1, a3);
        chk("stall_accept_cycle", 32'(a3), 32'(a2 + 7));
        exp_switch(a3, "sw_to1", 2'd0, 2'd1, 8'h5A, 1'b1);
        @(negedge clk);
        sel_valid = 1'b0;
        while (cyc < a3 + 8) @(negedge clk);

        // Restart the active design.
        do_req(2'd1, a4);
        for (int k = 0; k < 4; k++) expect_at(a4 + k, "restart", 8'h00, 4'b0010, 4'b1111, 2'd1, 1'b0, 1'b1);
        expect_at(a4 + 4, "restart_run", 8'h00, 4'b0010, 4'b1101, 2'd1, 1'b1, 1'b0);
        expect_at(a4 + 5, "restart_io", 8'h5A, 4'b0010, 4'b1101, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        sel_valid = 1'b0;
        while (cyc < a4 + 6) @(negedge clk);

        // Reset asserted while switching to design 3 is in RST.
        do_req(2'd3, a5);
        expect_at(a5, "to3_drain", 8'h00, 4'b0000, 4'b1111, 2'd1, 1'b0, 1'b1);
        expect_at(a5 + 2, "to3_rst", 8'h00, 4'b1000, 4'b1111, 2'd3, 1'b0, 1'b1);
        @(negedge clk);
        sel_valid = 1'b0;
        while (cyc < a5 + 3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({io_out, des_clk_en, des_reset, active_id, sel_ready, busy}),
            32'({8'h00, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b1}));
        expect_at(a5 + 4, "in_reset", 8'h00, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cr = cyc;
        for (int k = 1; k < 4; k++) expect_at(cr + k, "rerelease", 8'h00, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b1);
        expect_at(cr + 4, "rerelease_run", 8'h00, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);
        expect_at(cr + 5, "rerelease_io", 8'h77, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0);
        while (cyc < cr + 6) @(negedge clk);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: check for cycle %0d never reached", mon_e.name, mon_e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
